vga_pixel_fifo: RTL and testbench
=================================

VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 Parameter X_W, default 8: pixel x coordinate width.
REQ-002 Parameter Y_W, default 7: pixel y coordinate width.
REQ-003 Parameter COLOUR_W, default 3: colour width.
REQ-004 Parameter DEPTH, default 16: entry count; SHALL be a power of two, minimum 2.
REQ-005 Parameter FLUSH_ON_CLEAR, default 0: 1 means an accepted clear discards all queued entries.
REQ-006 The clock and reset ports SHALL be: CLOCK_50 in 1, the single clock; resetn in 1, asynchronous active-low reset.
REQ-007 Producer-side inputs SHALL be: x in X_W; y in Y_W; colour in COLOUR_W; plot in 1, push pixel; vga_resetn in 1, active-low clear request.
REQ-008 Consumer-side outputs SHALL be: out_valid out 1; out_x out X_W; out_y out Y_W; out_colour out COLOUR_W; out_clear out 1, which marks a clear entry.
REQ-009 The consumer-side input SHALL be: out_ready in 1, the consumer accepts the head entry.
REQ-010 Status outputs SHALL be: count out clog2(DEPTH+1), entries held; full out 1; overflow out 1, sticky pixel-drop flag.

Function
REQ-011 Each entry SHALL hold {clear, x, y, colour}; for a clear entry, x, y and colour SHALL be zero.
REQ-012 A clear event SHALL be a 1->0 transition of vga_resetn, detected against a registered copy whose reset value is 1; holding vga_resetn low SHALL yield exactly one clear event.
REQ-013 plot=1 on a cycle without a clear event SHALL push a pixel entry, unless the FIFO is full and no pop occurs that cycle.
REQ-014 When a clear event and plot=1 occur on the same cycle, only the clear entry SHALL be pushed; the pixel is silently discarded and overflow does not change.
REQ-015 A clear event SHALL never be dropped: if the FIFO is full and FLUSH_ON_CLEAR=0, the clear SHALL overwrite the newest entry and set overflow.
REQ-016 With FLUSH_ON_CLEAR=1, an accepted clear SHALL leave the FIFO holding exactly that one clear entry on the next cycle (count=1), whatever the pop that cycle.
REQ-017 A pixel push attempted while full with no pop SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-018 A pop SHALL occur when out_valid=1 and out_ready=1 on a rising edge.
REQ-019 When full, a push and a pop on the same cycle SHALL both succeed and count SHALL remain DEPTH.
REQ-020 Output SHALL be first-word-fall-through: an entry pushed into an empty FIFO SHALL appear on out_* with out_valid=1 one cycle after the push edge.
REQ-021 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH; full SHALL be derived from count==DEPTH.
REQ-023 count SHALL be registered and SHALL change by at most +1 or -1 per cycle, except under REQ-016.

Reset
REQ-024 While resetn=0, the block SHALL hold: count=0, out_valid=0, full=0, overflow=0, out_clear=0, out_x/out_y/out_colour=0, pointers=0, and the vga_resetn history register=1.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously.
REQ-026 After release, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro VGA_PIXEL_FIFO_STATS_EN defined: the block SHALL add outputs drop_count (16 bits, saturating, counting dropped pixels per REQ-017) and high_water (clog2(DEPTH+1) bits, maximum count seen); both reset to 0.
REQ-028 Macro undefined: these outputs and their registers SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package vga_fifo_pkg SHALL hold the default widths (8/7/3) and a clog2-based count-width function.
REQ-030 Storage SHALL live in sub-module vga_pixel_fifo_mem: a simple dual-port array, with synchronous write and asynchronous read, sized DEPTH x (1+X_W+Y_W+COLOUR_W).

Verification
REQ-031 Push (x=5, y=3, colour=7) with out_ready=0 -> next cycle out_valid=1, out_x=5, out_y=3, out_colour=7, out_clear=0, count=1.
REQ-032 DEPTH=16: 17 consecutive plots with no pop -> count=16, full=1, overflow=1, 17th pixel absent on drain; stats build shows drop_count=1 and high_water=16.
REQ-033 Full FIFO with out_ready=1 and plot=1 for 20 cycles -> count stays 16 and entries drain in order across pointer wrap.
REQ-034 vga_resetn held low 5 cycles with plot=1 at the falling edge -> exactly one entry, with out_clear=1 and x/y/colour=0.
REQ-035 FLUSH_ON_CLEAR=1 with 10 queued entries, then a clear event -> next cycle count=1 and the head is the clear entry.
REQ-036 resetn pulsed low mid-drain with 8 entries -> count=0 and out_valid=0 at once; a push after release appears after one cycle.

Source files
------------

// File: rtl/vga_fifo_pkg.sv
// Shared defaults and width helpers for the VGA pixel FIFO.
// Each queue entry is a flat vector {clear, x, y, colour}; widths are
// parameters of the top module, so only the defaults live here.
package vga_fifo_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_DEPTH    = 16;

    // Width of the saturating dropped-pixel counter (statistics build).
    localparam int STAT_W = 16;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for a power-of-two depth (never narrower than one bit).
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/vga_pixel_fifo_mem.sv
// Entry storage for the VGA pixel FIFO: simple dual-port array with a
// synchronous write port and an asynchronous (combinational) read port.
// The asynchronous read lets the head entry fall through to the outputs
// in the same cycle the read pointer settles. Contents are not reset;
// the top module masks the outputs whenever the queue is empty.
module vga_pixel_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 19,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_array [DEPTH];

    // Write port: one entry per clock when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/vga_pixel_fifo.sv
// VGA pixel FIFO: queues {x, y, colour} plot requests and screen-clear
// markers between a pixel producer and a VGA framebuffer writer.
// A clear marker is generated on every falling edge of vga_resetn and is
// never lost: when the queue is full it replaces the newest entry (or, with
// FLUSH_ON_CLEAR=1, it replaces the whole queue).
// Optional feature: define VGA_PIXEL_FIFO_STATS_EN to add the drop_count
// and high_water statistics outputs.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module vga_pixel_fifo
    import vga_fifo_pkg::*;
#(
    parameter int X_W            = DEF_X_W,
    parameter int Y_W            = DEF_Y_W,
    parameter int COLOUR_W       = DEF_COLOUR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter bit FLUSH_ON_CLEAR = 1'b0
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [X_W-1:0]              x,
    input  logic [Y_W-1:0]              y,
    input  logic [COLOUR_W-1:0]         colour,
    input  logic                        plot,
    input  logic                        vga_resetn,
    output logic                        out_valid,
    output logic [X_W-1:0]              out_x,
    output logic [Y_W-1:0]              out_y,
    output logic [COLOUR_W-1:0]         out_colour,
    output logic                        out_clear,
    input  logic                        out_ready,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        overflow
`ifdef VGA_PIXEL_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0]           drop_count,
    output logic [cnt_width(DEPTH)-1:0] high_water
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int ENT_W = 1 + X_W + Y_W + COLOUR_W;

    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [ENT_W-1:0] CLEAR_ENTRY = {1'b1, {(ENT_W-1){1'b0}}};

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             vga_resetn_reg;

    logic             mem_wr_en;
    logic [PTR_W-1:0] mem_wr_addr;
    logic [ENT_W-1:0] mem_wr_data;
    logic [ENT_W-1:0] head_entry;

    logic             full_w;
    logic             pop;
    logic             clear_event;
    logic             pixel_drop;

    assign full_w      = (count_reg == CNT_FULL);
    assign out_valid   = (count_reg != '0);
    assign pop         = out_valid && out_ready;
    // Only the 1->0 transition counts, so a held-low vga_resetn clears once.
    assign clear_event = vga_resetn_reg && !vga_resetn;

    vga_pixel_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (CLOCK_50),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // Next-state for pointers, occupancy and overflow, plus the write port.
    always_comb begin
        mem_wr_en     = 1'b0;
        mem_wr_addr   = wr_ptr_reg;
        mem_wr_data   = {1'b0, x, y, colour};
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        pixel_drop    = 1'b0;

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            count_next  = count_reg - CNT_ONE;
        end

        if (clear_event) begin
            // A coincident plot is discarded in favour of the clear marker.
            mem_wr_data = CLEAR_ENTRY;
            mem_wr_en   = 1'b1;
            if (FLUSH_ON_CLEAR) begin
                // Restart the queue at the write slot; any pop is moot.
                rd_ptr_next = wr_ptr_reg;
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                count_next  = CNT_ONE;
            end else if (!full_w || pop) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                count_next  = pop ? count_reg : count_reg + CNT_ONE;
            end else begin
                // Full with no room: sacrifice the newest entry, never the head.
                mem_wr_addr   = wr_ptr_reg - PTR_ONE;
                overflow_next = 1'b1;
            end
        end else if (plot) begin
            if (!full_w || pop) begin
                mem_wr_en   = 1'b1;
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                count_next  = pop ? count_reg : count_reg + CNT_ONE;
            end else begin
                pixel_drop    = 1'b1;
                overflow_next = 1'b1;
            end
        end
    end

    // Queue state registers; reset empties the queue at once.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            vga_resetn_reg <= 1'b1;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            vga_resetn_reg <= vga_resetn;
        end
    end

    // Head entry is masked to zero while the queue is empty (and in reset).
    assign {out_clear, out_x, out_y, out_colour} = out_valid ? head_entry : '0;

    assign count    = count_reg;
    assign full     = full_w;
    assign overflow = overflow_reg;

`ifdef VGA_PIXEL_FIFO_STATS_EN
    logic [STAT_W-1:0] drop_count_reg;
    logic [CNT_W-1:0]  high_water_reg;

    // Saturating count of pixels refused for lack of space.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            drop_count_reg <= '0;
        end else if (pixel_drop && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + STAT_W'(1);
        end
    end

    // Peak occupancy, tracked on the value count is about to take.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            high_water_reg <= '0;
        end else if (count_next > high_water_reg) begin
            high_water_reg <= count_next;
        end
    end

    assign drop_count = drop_count_reg;
    assign high_water = high_water_reg;
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo. Two instances share one stimulus
// stream: u_dut0 keeps entries on a clear, u_dut1 flushes on a clear.
// Both are compared every cycle against a queue-based reference model.
module tb_vga_pixel_fifo;
    import vga_fifo_pkg::*;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    localparam int DEPTH = 16;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int ENT_W = 1 + X_W + Y_W + C_W;

    typedef logic [ENT_W-1:0] ent_t;

    logic             CLOCK_50 = 1'b0;
    logic             resetn;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [C_W-1:0]   colour;
    logic             plot;
    logic             vga_resetn;
    logic             out_ready;

    logic             ov0, ocl0, full0, ovf0;
    logic [X_W-1:0]   ox0;
    logic [Y_W-1:0]   oy0;
    logic [C_W-1:0]   oc0;
    logic [CNT_W-1:0] cnt0;
    logic             ov1, ocl1, full1, ovf1;
    logic [X_W-1:0]   ox1;
    logic [Y_W-1:0]   oy1;
    logic [C_W-1:0]   oc1;
    logic [CNT_W-1:0] cnt1;
`ifdef VGA_PIXEL_FIFO_STATS_EN
    logic [15:0]      drop0, drop1;
    logic [CNT_W-1:0] hw0, hw1;
`endif

    vga_pixel_fifo #(.DEPTH(DEPTH), .FLUSH_ON_CLEAR(1'b0)) u_dut0 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .x(x), .y(y), .colour(colour),
        .plot(plot), .vga_resetn(vga_resetn), .out_valid(ov0), .out_x(ox0),
        .out_y(oy0), .out_colour(oc0), .out_clear(ocl0), .out_ready(out_ready),
        .count(cnt0), .full(full0), .overflow(ovf0)
`ifdef VGA_PIXEL_FIFO_STATS_EN
        , .drop_count(drop0), .high_water(hw0)
`endif
    );

    vga_pixel_fifo #(.DEPTH(DEPTH), .FLUSH_ON_CLEAR(1'b1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .x(x), .y(y), .colour(colour),
        .plot(plot), .vga_resetn(vga_resetn), .out_valid(ov1), .out_x(ox1),
        .out_y(oy1), .out_colour(oc1), .out_clear(ocl1), .out_ready(out_ready),
        .count(cnt1), .full(full1), .overflow(ovf1)
`ifdef VGA_PIXEL_FIFO_STATS_EN
        , .drop_count(drop1), .high_water(hw1)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model state.
    ent_t mq0[$];
    ent_t mq1[$];
    bit   movf [2];
    int   mdrop[2];
    int   mhw  [2];
    bit   mhist;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            movf[k]  = 1'b0;
            mdrop[k] = 0;
            mhw[k]   = 0;
        end
        mhist = 1'b1;
    endtask

    // One clock of the behavioural FIFO; k=1 is the flush-on-clear instance.
    task automatic model_one(input int k, input bit clr);
        ent_t cur[$];
        ent_t px;
        ent_t ce;
        bit   pop;
        if (k == 0) cur = mq0; else cur = mq1;
        px  = {1'b0, x, y, colour};
        ce  = '0;
        ce[ENT_W-1] = 1'b1;
        pop = out_ready && (cur.size() > 0);
        if (clr) begin
            if (k == 1) begin
                cur.delete();
                cur.push_back(ce);
            end else if (cur.size() < DEPTH || pop) begin
                if (pop) void'(cur.pop_front());
                cur.push_back(ce);
            end else begin
                cur[cur.size()-1] = ce;
                movf[k] = 1'b1;
            end
        end else if (plot) begin
            if (cur.size() < DEPTH || pop) begin
                if (pop) void'(cur.pop_front());
                cur.push_back(px);
            end else begin
                movf[k] = 1'b1;
                if (mdrop[k] < 65535) mdrop[k]++;
            end
        end else if (pop) begin
            void'(cur.pop_front());
        end
        if (cur.size() > mhw[k]) mhw[k] = cur.size();
        if (k == 0) mq0 = cur; else mq1 = cur;
    endtask

    task automatic compare_all();
        check_eq("valid0", 32'(ov0), 32'(mq0.size() > 0));
        check_eq("count0", 32'(cnt0), 32'(mq0.size()));
        check_eq("full0", 32'(full0), 32'(mq0.size() == DEPTH));
        check_eq("ovf0", 32'(ovf0), 32'(movf[0]));
        if (mq0.size() > 0) check_eq("head0", 32'({ocl0, ox0, oy0, oc0}), 32'(mq0[0]));
        check_eq("valid1", 32'(ov1), 32'(mq1.size() > 0));
        check_eq("count1", 32'(cnt1), 32'(mq1.size()));
        check_eq("full1", 32'(full1), 32'(mq1.size() == DEPTH));
        check_eq("ovf1", 32'(ovf1), 32'(movf[1]));
        if (mq1.size() > 0) check_eq("head1", 32'({ocl1, ox1, oy1, oc1}), 32'(mq1[0]));
`ifdef VGA_PIXEL_FIFO_STATS_EN
        check_eq("drop0", 32'(drop0), 32'(mdrop[0]));
        check_eq("hw0", 32'(hw0), 32'(mhw[0]));
        check_eq("drop1", 32'(drop1), 32'(mdrop[1]));
        check_eq("hw1", 32'(hw1), 32'(mhw[1]));
`endif
    endtask

    task automatic tick();
        bit clr;
        @(posedge CLOCK_50);
        clr = mhist && !vga_resetn;
        model_one(0, clr);
        model_one(1, clr);
        mhist = vga_resetn;
        #1;
        compare_all();
    endtask

    task automatic rand_pixel();
        x      = X_W'($urandom);
        y      = Y_W'($urandom);
        colour = C_W'($urandom);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic apply_reset();
        #3 resetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_data0", 32'({ocl0, ox0, oy0, oc0}), 32'd0);
        check_eq("rst_data1", 32'({ocl1, ox1, oy1, oc1}), 32'd0);
        @(posedge CLOCK_50);
        #1;
        compare_all();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; plot = 1'b0; vga_resetn = 1'b1; out_ready = 1'b0;
        x = '0; y = '0; colour = '0;
        model_reset();
        #15;
        compare_all();
        check_eq("rst_data0", 32'({ocl0, ox0, oy0, oc0}), 32'd0);
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;

        // Single push of (5,3,7) with the consumer stalled.
        x = 8'd5; y = 7'd3; colour = 3'd7; plot = 1'b1;
        tick();
        plot = 1'b0;
        check_eq("push_valid", 32'(ov0), 32'd1);
        check_eq("push_x", 32'(ox0), 32'd5);
        check_eq("push_y", 32'(oy0), 32'd3);
        check_eq("push_colour", 32'(oc0), 32'd7);
        check_eq("push_clear", 32'(ocl0), 32'd0);
        check_eq("push_count", 32'(cnt0), 32'd1);
        tick();
        check_eq("stall_x", 32'(ox0), 32'd5);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;

        // Seventeen plots with no pop: the last one is dropped.
        plot = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rand_pixel();
            tick();
        end
        plot = 1'b0;
        check_eq("fill_count", 32'(cnt0), 32'd16);
        check_eq("fill_full", 32'(full0), 32'd1);
        check_eq("fill_ovf", 32'(ovf0), 32'd1);
`ifdef VGA_PIXEL_FIFO_STATS_EN
        check_eq("fill_drop", 32'(drop0), 32'd1);
        check_eq("fill_hw", 32'(hw0), 32'd16);
`endif

        // Full, streaming push and pop together across pointer wrap.
        out_ready = 1'b1; plot = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_pixel();
            tick();
            check_eq("stream_count", 32'(cnt0), 32'd16);
        end
        plot = 1'b0;
        repeat (17) tick();
        check_eq("drained", 32'(cnt0), 32'd0);
        out_ready = 1'b0;

        // vga_resetn held low for five cycles, plot asserted at the fall.
        rand_pixel();
        vga_resetn = 1'b0; plot = 1'b1;
        tick();
        plot = 1'b0;
        repeat (4) tick();
        check_eq("clr_count", 32'(cnt0), 32'd1);
        check_eq("clr_flag", 32'(ocl0), 32'd1);
        check_eq("clr_data", 32'({ox0, oy0, oc0}), 32'd0);
        vga_resetn = 1'b1;
        tick();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;

        // Ten queued pixels followed by a clear event.
        plot = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_pixel();
            tick();
        end
        plot = 1'b0;
        vga_resetn = 1'b0;
        tick();
        check_eq("flush_count", 32'(cnt1), 32'd1);
        check_eq("flush_head", 32'(ocl1), 32'd1);
        check_eq("noflush_count", 32'(cnt0), 32'd11);
        vga_resetn = 1'b1;
        tick();

        // Drain to eight entries, then pulse reset mid-drain.
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("pre_rst_count", 32'(cnt0), 32'd8);
        apply_reset();
        check_eq("rst_count", 32'(cnt0), 32'd0);
        check_eq("rst_valid", 32'(ov0), 32'd0);
        out_ready = 1'b0; plot = 1'b1;
        x = 8'd200; y = 7'd99; colour = 3'd2;
        tick();
        plot = 1'b0;
        check_eq("post_rst_valid", 32'(ov0), 32'd1);
        check_eq("post_rst_x", 32'(ox0), 32'd200);

        // Randomized traffic including occasional clear requests.
        for (int i = 0; i < 2000; i++) begin
            plot      = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            if (vga_resetn) vga_resetn = !($urandom_range(0, 99) < 4);
            else            vga_resetn = ($urandom_range(0, 99) < 35);
            rand_pixel();
            tick();
            if (i == 1000) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
